data_memory: RTL



---
 rtl/data_memory.sv | 117 +++++++++++
 1 files changed

// File: rtl/data_memory.sv
`default_nettype none
//============================================================================
// Module      : data_memory
// Description : 256 x 8 byte-addressed data memory on the CPU load/store
//               port. Every access takes a fixed, configurable number of
//               BUSY cycles, during which BUSYWAIT stalls the CPU.
// Revision    : 1.0  initial release
//============================================================================
module data_memory #(
  parameter int LATENCY = 5  // BUSY cycles per access, 1..255
) (
  input  logic       CLK,
  input  logic       RESET,      // synchronous, active-low
  input  logic       READ,
  input  logic       WRITE,
  input  logic [7:0] ADDRESS,
  input  logic [7:0] WRITEDATA,
  output logic [7:0] READDATA,
  output logic       BUSYWAIT
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // cnt counts down to zero, so BUSY lasts exactly LATENCY cycles
  localparam logic [7:0] C_CNT_INIT = 8'(LATENCY - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       op_wr_q, op_wr_d;
  logic [7:0] readdata_q, readdata_d;
  logic [7:0] mem_q [256];
  logic       mem_we;

  // Next-state, request capture and access completion
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    op_wr_d    = op_wr_q;
    readdata_d = readdata_q;
    mem_we     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // READ and WRITE together is an illegal request and is ignored
        if (READ ^ WRITE) begin
          addr_d  = ADDRESS;
          data_d  = WRITEDATA;
          op_wr_d = WRITE;
          cnt_d   = C_CNT_INIT;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        // Only the latched request is used; live inputs cannot abort it
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          if (op_wr_q) begin
            mem_we = 1'b1;
          end else begin
            readdata_d = mem_q[addr_q];
          end
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // One dead cycle so the still-asserted request is not re-accepted
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, request registers and storage; reset clears everything
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      addr_q     <= 8'd0;
      data_q     <= 8'd0;
      op_wr_q    <= 1'b0;
      readdata_q <= 8'd0;
      for (int i = 0; i < 256; i++) begin
        mem_q[i] <= 8'd0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      op_wr_q    <= op_wr_d;
      readdata_q <= readdata_d;
      if (mem_we) begin
        mem_q[addr_q] <= data_q;
      end
    end
  end

  // Stall in the request cycle itself (IDLE) and throughout BUSY
  always_comb begin
    BUSYWAIT = RESET && (((state_q == S_IDLE) && (READ ^ WRITE)) ||
                         (state_q == S_BUSY));
  end

  assign READDATA = readdata_q;

endmodule
`default_nettype wire
